// File: rtl/apb_axi_status_regs_if.sv
// APB3 bus bundle for the AXI status register block.
// Master drives the request; slave returns data, ready and error.
interface apb_axi_status_regs_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_axi_status_regs.sv
// APB3 status/error register block for the AXI interconnect.
// AXI_STATUS_PERF_CNT_EN adds the AW/AR lifetime handshake counters.
module apb_axi_status_regs #(
  parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
  parameter int NUM_SID = 4,
  parameter int SID_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  apb_axi_status_regs_if.slave     apb,
  input  logic                     aw_decode_err,
  input  logic                     ar_decode_err,
  input  logic [NUM_SID*SID_W-1:0] aw_sid,
  input  logic [NUM_SID*SID_W-1:0] ar_sid,
  input  logic                     aw_hs,
  input  logic                     ar_hs,
  output logic                     irq
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e      state_q;
  logic [31:0] prdata_q;
  logic        pready_q;
  logic        pslverr_q;

  logic [1:0]  sts_q, sts_d;
  logic [1:0]  irq_en_q, irq_en_d;
  logic        irq_q, irq_d;
  logic [2:0]  aw_out_q, aw_out_d;
  logic [2:0]  ar_out_q, ar_out_d;

  logic [31:0] off;
  logic [2:0]  idx;
  logic        hit;
  logic        ro;
  logic        dis;
  logic [31:0] rd_val;
  logic        slv_err_d;
  logic [31:0] rdata_d;
  logic        commit;

`ifdef AXI_STATUS_PERF_CNT_EN
  logic [CNT_W-1:0] aw_tot_q, aw_tot_d;
  logic [CNT_W-1:0] ar_tot_q, ar_tot_d;
`endif

  assign apb.prdata  = prdata_q;
  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign irq         = irq_q;

  always_comb begin
    off    = apb.paddr - BASE_ADDR;
    idx    = off[4:2];
    hit    = (apb.paddr[1:0] == 2'b00) && (off <= 32'h1C);
    ro     = 1'b0;
    dis    = 1'b0;
    rd_val = '0;
    case (idx)
      3'd0: rd_val = {30'd0, sts_q};
      3'd1: begin rd_val = 32'(aw_sid); ro = 1'b1; end
      3'd2: begin rd_val = 32'(ar_sid); ro = 1'b1; end
      3'd3: begin rd_val = 32'(aw_out_q); ro = 1'b1; end
      3'd4: begin rd_val = 32'(ar_out_q); ro = 1'b1; end
`ifdef AXI_STATUS_PERF_CNT_EN
      3'd5: rd_val = 32'(aw_tot_q);
      3'd6: rd_val = 32'(ar_tot_q);
`else
      3'd5: dis = 1'b1;
      3'd6: dis = 1'b1;
`endif
      default: rd_val = {30'd0, irq_en_q};
    endcase
    slv_err_d = !hit || (apb.pwrite && ro) || dis;
    rdata_d   = slv_err_d ? 32'd0 : rd_val;
  end

  // pslverr_q was decoded from this same address in WAIT
  assign commit = (state_q == RESP) && apb.pwrite && !pslverr_q && hit;

  always_comb begin
    sts_d[1] = (sts_q[1] & ~(commit && idx == 3'd0 && apb.pwdata[1]))
             | aw_decode_err;
    sts_d[0] = (sts_q[0] & ~(commit && idx == 3'd0 && apb.pwdata[0]))
             | ar_decode_err;
    irq_en_d = (commit && idx == 3'd7) ? apb.pwdata[1:0] : irq_en_q;
    irq_d    = |(sts_q & irq_en_q);
    aw_out_d = '0;
    ar_out_d = '0;
    for (int i = 0; i < NUM_SID; i++) begin
      aw_out_d = aw_out_d + 3'(aw_sid[i*SID_W +: SID_W] != '0);
      ar_out_d = ar_out_d + 3'(ar_sid[i*SID_W +: SID_W] != '0);
    end
  end

`ifdef AXI_STATUS_PERF_CNT_EN
  always_comb begin
    aw_tot_d = aw_tot_q;
    if (commit && idx == 3'd5)
      aw_tot_d = CNT_W'(aw_hs);
    else if (aw_hs && aw_tot_q != '1)
      aw_tot_d = aw_tot_q + CNT_W'(1);
    ar_tot_d = ar_tot_q;
    if (commit && idx == 3'd6)
      ar_tot_d = CNT_W'(ar_hs);
    else if (ar_hs && ar_tot_q != '1)
      ar_tot_d = ar_tot_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_tot_q <= '0;
      ar_tot_q <= '0;
    end else begin
      aw_tot_q <= aw_tot_d;
      ar_tot_q <= ar_tot_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sts_q    <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
      aw_out_q <= '0;
      ar_out_q <= '0;
    end else begin
      sts_q    <= sts_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      aw_out_q <= aw_out_d;
      ar_out_q <= ar_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pready_q <= 1'b0;
          if (apb.psel && apb.penable) state_q <= WAIT;
        end
        WAIT: begin
          if (!apb.psel) begin
            state_q <= IDLE;
          end else begin
            state_q   <= RESP;
            pready_q  <= 1'b1;
            prdata_q  <= rdata_d;
            pslverr_q <= slv_err_d;
          end
        end
        default: begin
          pready_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  logic unused_ok;
`ifdef AXI_STATUS_PERF_CNT_EN
  assign unused_ok = ^{apb.pwdata[31:2], off[1:0]};
`else
  assign unused_ok = ^{apb.pwdata[31:2], off[1:0], aw_hs, ar_hs};
`endif

endmodule

// File: tb/tb_apb_axi_status_regs.sv
// Bench for apb_axi_status_regs: vector table plus hand sequences.
// Build with AXI_STATUS_PERF_CNT_EN to cover the counters (CNT_W=4).
module tb_apb_axi_status_regs;
  localparam logic [31:0] BASE = 32'h5000_0000;
`ifdef AXI_STATUS_PERF_CNT_EN
  localparam int  CNT_W = 4;
  localparam bit  PERF  = 1'b1;
`else
  localparam int  CNT_W = 16;
  localparam bit  PERF  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aw_decode_err, ar_decode_err;
  logic [31:0] aw_sid, ar_sid;
  logic        aw_hs, ar_hs;
  logic        irq;

  apb_axi_status_regs_if apb_if ();

  apb_axi_status_regs #(
    .BASE_ADDR(BASE),
    .NUM_SID  (4),
    .SID_W    (8),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .apb          (apb_if),
    .aw_decode_err(aw_decode_err),
    .ar_decode_err(ar_decode_err),
    .aw_sid       (aw_sid),
    .ar_sid       (ar_sid),
    .aw_hs        (aw_hs),
    .ar_hs        (ar_hs),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] off;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
  } exp_t;

  exp_t sb[$];
  vec_t vt[16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // pls[0] pulses ar_decode_err, pls[1] pulses aw_hs in the RESP cycle
  task automatic xfer(input logic wr, input logic [31:0] off,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input logic er, input logic [1:0] pls);
    exp_t e;
    int   n;
    sb.push_back('{rd, er, !wr || er});
    @(posedge clk); #1;
    apb_if.psel    = 1'b1;
    apb_if.penable = 1'b0;
    apb_if.pwrite  = wr;
    apb_if.paddr   = BASE + off;
    apb_if.pwdata  = wd;
    @(posedge clk); #1;
    apb_if.penable = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!apb_if.pready && n < 8);
    chk("latency", 32'(n), 32'd2);
    e = sb.pop_front();
    if (apb_if.pready) begin
      if (e.chk_rd) chk("prdata", apb_if.prdata, e.rd);
      chk("pslverr", 32'(apb_if.pslverr), 32'(e.err));
    end
    ar_decode_err = pls[0];
    aw_hs         = pls[1];
    @(posedge clk); #1;
    ar_decode_err  = 1'b0;
    aw_hs          = 1'b0;
    apb_if.psel    = 1'b0;
    apb_if.penable = 1'b0;
    chk("pready_1cyc", 32'(apb_if.pready), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_n = 1'b0;
    aw_decode_err = 1'b0; ar_decode_err = 1'b0;
    aw_sid = '0; ar_sid = '0; aw_hs = 1'b0; ar_hs = 1'b0;
    apb_if.psel = 1'b0; apb_if.penable = 1'b0; apb_if.pwrite = 1'b0;
    apb_if.paddr = '0; apb_if.pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", 32'(apb_if.pready), 32'd0);
    chk("rst_pslverr", 32'(apb_if.pslverr), 32'd0);
    chk("rst_prdata", apb_if.prdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;

    xfer(0, 32'h00, 0, 32'h0, 0, 2'b00);
    xfer(0, 32'h04, 0, 32'h0, 0, 2'b00);
    xfer(0, 32'h1C, 0, 32'h0, 0, 2'b00);

    aw_sid = 32'h0007_0003;
    ar_sid = 32'h0100_0000;
    repeat (2) @(posedge clk);

    vt[0]  = '{0, 32'h04, 0, 32'h0007_0003, 0};
    vt[1]  = '{0, 32'h0C, 0, 32'd2, 0};
    vt[2]  = '{0, 32'h08, 0, 32'h0100_0000, 0};
    vt[3]  = '{0, 32'h10, 0, 32'd1, 0};
    vt[4]  = '{0, 32'h20, 0, 32'd0, 1};
    vt[5]  = '{0, 32'h02, 0, 32'd0, 1};
    vt[6]  = '{0, 32'hFFFF_FFFC, 0, 32'd0, 1};
    vt[7]  = '{1, 32'h04, 32'hFFFF_FFFF, 32'd0, 1};
    vt[8]  = '{0, 32'h04, 0, 32'h0007_0003, 0};
    vt[9]  = '{1, 32'h0C, 32'd1, 32'd0, 1};
    vt[10] = '{1, 32'h1C, 32'd3, 32'd0, 0};
    vt[11] = '{0, 32'h1C, 0, 32'd3, 0};
    vt[12] = '{1, 32'h1C, 32'd0, 32'd0, 0};
    vt[13] = '{0, 32'h14, 0, 32'd0, !PERF};
    vt[14] = '{0, 32'h18, 0, 32'd0, !PERF};
    vt[15] = '{0, 32'h1D, 0, 32'd0, 1};
    for (int i = 0; i < 16; i++)
      xfer(vt[i].wr, vt[i].off, vt[i].wd, vt[i].rd, vt[i].err, 2'b00);

    // AW error raises irq one cycle after the flag sets
    xfer(1, 32'h1C, 32'd2, 0, 0, 2'b00);
    @(posedge clk); #1 aw_decode_err = 1'b1;
    @(posedge clk); #1 aw_decode_err = 1'b0;
    chk("irq_lag", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_set", 32'(irq), 32'd1);
    xfer(0, 32'h00, 0, 32'd2, 0, 2'b00);
    xfer(1, 32'h00, 32'd2, 0, 0, 2'b00);
    chk("irq_hold", 32'(irq), 32'd1);
    @(posedge clk); #1;
    chk("irq_clr", 32'(irq), 32'd0);
    xfer(0, 32'h00, 0, 32'd0, 0, 2'b00);

    // set pulse beats a simultaneous W1C
    @(posedge clk); #1 ar_decode_err = 1'b1;
    @(posedge clk); #1 ar_decode_err = 1'b0;
    xfer(0, 32'h00, 0, 32'd1, 0, 2'b00);
    xfer(1, 32'h00, 32'd1, 0, 0, 2'b01);
    xfer(0, 32'h00, 0, 32'd1, 0, 2'b00);
    chk("irq_masked", 32'(irq), 32'd0);
    xfer(1, 32'h00, 32'd1, 0, 0, 2'b00);
    xfer(0, 32'h00, 0, 32'd0, 0, 2'b00);

    // psel drops in WAIT: no pready, no write
    @(posedge clk); #1;
    apb_if.psel = 1'b1; apb_if.penable = 1'b0; apb_if.pwrite = 1'b1;
    apb_if.paddr = BASE + 32'h1C; apb_if.pwdata = 32'd1;
    @(posedge clk); #1 apb_if.penable = 1'b1;
    @(posedge clk); #1;
    apb_if.psel = 1'b0; apb_if.penable = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= apb_if.pready;
    end
    chk("abort_pready", 32'(seen), 32'd0);
    xfer(0, 32'h1C, 0, 32'd2, 0, 2'b00);

`ifdef AXI_STATUS_PERF_CNT_EN
    repeat (20) begin
      @(posedge clk); #1 aw_hs = 1'b1;
      @(posedge clk); #1 aw_hs = 1'b0;
    end
    xfer(0, 32'h14, 0, 32'd15, 0, 2'b00);
    xfer(0, 32'h18, 0, 32'd0, 0, 2'b00);
    xfer(1, 32'h14, 32'hDEAD_BEEF, 0, 0, 2'b10);
    xfer(0, 32'h14, 0, 32'd1, 0, 2'b00);
`else
    xfer(0, 32'h18, 0, 32'd0, 1, 2'b00);
    xfer(1, 32'h14, 32'd5, 32'd0, 1, 2'b00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_axi_status_regs.md
Name: apb_axi_status_regs

Overview:
- APB3 slave exposing AXI interconnect status: sticky decode-error flags, outstanding-ID slot snapshots, outstanding counts, lifetime handshake counters and an interrupt.
- Generalises the earlier fixed 4-slot read-only status block:
  - slot count and width are parametrised
  - real APB handshake with one wait state and PSLVERR
  - write-1-to-clear error flags
  - interrupt enable register
- Sits on the config APB segment next to the interconnect address decoders.

Parameters:
BASE_ADDR  32'h5000_0000  byte base of register window
NUM_SID    4              outstanding-ID slots per channel, 1..4
SID_W      8              width of one slot; NUM_SID*SID_W <= 32
CNT_W      16             width of lifetime handshake counters, 1..32

Ports:
clk            in   1               clock
rst_n          in   1               synchronous active-low reset
psel           in   1               APB select
penable        in   1               APB enable
pwrite         in   1               APB write
paddr          in   32              APB byte address
pwdata         in   32              APB write data
prdata         out  32              APB read data, valid while pready=1
pready         out  1               APB ready
pslverr        out  1               APB error, valid while pready=1
aw_decode_err  in   1               1-cycle pulse: AW decode miss
ar_decode_err  in   1               1-cycle pulse: AR decode miss
aw_sid         in   NUM_SID*SID_W   packed AW slots, slot0 in LSBs; 0 = empty
ar_sid         in   NUM_SID*SID_W   packed AR slots
aw_hs          in   1               pulse: AW address handshake accepted
ar_hs          in   1               pulse: AR address handshake accepted
irq            out  1               level interrupt, registered

Behaviour:
- Reset (clk, rst_n synchronous active-low): all registers 0.
  - prdata=0, pready=0, pslverr=0, irq=0.
  - FSM goes to IDLE.
  - Reset mid-transfer aborts it; no write takes effect.
- FSM states IDLE -> WAIT -> RESP -> IDLE:
  - IDLE -> WAIT: psel & penable.
  - WAIT -> RESP: always. In WAIT, pready=0; the address is decoded, and prdata/pslverr are registered.
  - In RESP, pready=1 for exactly one cycle.
  - If psel drops in WAIT, return to IDLE with no write and no pready.
  - Access latency is 2 cycles after penable rises.
- Writes commit at the RESP clock edge, only when pslverr=0. Outside RESP, prdata holds its last value.
- Register map (offset from BASE_ADDR):
  - 0x00 ERR_STATUS RW1C: bit1 = AW sticky, bit0 = AR sticky; bits[31:2] read 0.
  - 0x04 AW_SID RO: aw_sid zero-extended to 32 bits.
  - 0x08 AR_SID RO: ar_sid zero-extended to 32 bits.
  - 0x0C AW_OUTST RO: count of nonzero AW slots, registered every cycle (1-cycle lag).
  - 0x10 AR_OUTST RO: same for AR.
  - 0x14 AW_TOTAL: see Optional Feature.
  - 0x18 AR_TOTAL: see Optional Feature.
  - 0x1C IRQ_EN RW: bit1 = AW enable, bit0 = AR enable.
- Sticky flags: a set pulse in the same cycle as a W1C clear wins, so the flag stays 1.
- irq is registered: irq <= |(ERR_STATUS[1:0] & IRQ_EN[1:0]). irq falls 1 cycle after the clearing write commits.
- pslverr=1 for any of:
  - paddr not 4-byte aligned
  - paddr outside BASE_ADDR..BASE_ADDR+0x1C
  - write to an RO register
  - access to a disabled counter
- On pslverr, prdata=0 and no state changes.

Optional Feature:
- Macro AXI_STATUS_PERF_CNT_EN.
- Defined:
  - AW_TOTAL/AR_TOTAL are CNT_W-bit counters, incremented on aw_hs/ar_hs and saturating at all-ones.
  - Reads return the counter zero-extended to 32 bits.
  - Any write to the counter's address clears it; pwdata is ignored.
  - A clear and an hs pulse in the same cycle yields 1.
- Undefined: no counter logic; 0x14/0x18 respond pslverr=1, prdata=0.

Test Plan:
- Reset, then read 0x00, 0x04 and 0x1C -> each returns 0, pready high exactly 2 cycles after penable, pslverr=0.
- aw_sid=32'h00_07_00_03 -> 0x04 reads 32'h00070003; 0x0C reads 2; read 0x20 -> pslverr=1, prdata=0; write 0x04 -> pslverr=1, value unchanged.
- Write IRQ_EN=2'b10, then an aw_decode_err pulse -> ERR_STATUS=2 and irq=1 the next cycle. Write 0x00 with 2 -> ERR_STATUS=0 and irq=0.
- W1C write of bit0 committing in the same cycle as an ar_decode_err pulse -> ERR_STATUS[0]=1 after the write.
- AXI_STATUS_PERF_CNT_EN defined, CNT_W=4:
  - 20 aw_hs pulses -> AW_TOTAL=15 (saturated).
  - Write 0x14 in the same cycle as an aw_hs pulse -> AW_TOTAL reads 1.
- AXI_STATUS_PERF_CNT_EN undefined: read 0x18 -> pslverr=1, prdata=0.
